// File: rtl/product_accumulator.sv
// Sums ACC_LEN consecutive signed products into a 40-bit accumulator, saturates each
// group total to 32 bits and queues it in a small FIFO drained by a valid/ready handshake.
module product_accumulator #(
  parameter int ACC_LEN    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Product,
  input  logic        Product_Valid,
  input  logic        Clr,
  output logic [31:0] Sum,
  output logic        Sum_Sat,
  output logic        Sum_Valid,
  input  logic        Sum_Ready,
  output logic [4:0]  Fifo_Count,
  output logic        Overflow
);

  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(ACC_LEN - 1);
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

  logic signed [39:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic [PW-1:0]      rd_ptr_reg;
  logic [PW-1:0]      wr_ptr_reg;
  logic [4:0]         count_reg;
  logic               ovf_reg;
  logic [31:0]        mem_val [FIFO_DEPTH];
  logic               mem_sat [FIFO_DEPTH];

  logic signed [39:0] total;
  logic               sat_hit;
  logic [31:0]        sat_val;
  logic               accept;
  logic               group_done;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               drop;

  // Total fits in 32 bits exactly when bits 39..31 are all copies of the sign.
  always_comb begin
    total   = acc_reg + {{8{Product[31]}}, Product};
    sat_hit = ~((&total[39:31]) | ~(|total[39:31]));
    sat_val = total[31:0];
    if (sat_hit) begin
      sat_val = total[39] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  assign accept     = Product_Valid & ~Clr;
  assign group_done = accept & (cnt_reg == LAST_IDX);
  assign fifo_empty = (count_reg == 5'd0);
  assign fifo_full  = (count_reg == DEPTH);
  assign pop        = ~fifo_empty & Sum_Ready;
  assign push       = group_done & (~fifo_full | pop);
  assign drop       = group_done & fifo_full & ~pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (Clr) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (accept) begin
      if (group_done) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= total;
        cnt_reg <= cnt_reg + CW'(1);
      end
      if (drop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + 5'(push) - 5'(pop);
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_val[wr_ptr_reg] <= sat_val;
      mem_sat[wr_ptr_reg] <= sat_hit;
    end
  end

  assign Sum        = fifo_empty ? 32'd0 : mem_val[rd_ptr_reg];
  assign Sum_Sat    = fifo_empty ? 1'b0 : mem_sat[rd_ptr_reg];
  assign Sum_Valid  = ~fifo_empty;
  assign Fifo_Count = count_reg;
  assign Overflow   = ovf_reg;

endmodule
